// File: rtl/sc_frog_game_controller_pkg.sv
// Shared types and constants for the Frogger game sequencer.
package sc_frog_game_controller_pkg;

  localparam int unsigned LivesWidth = 3;
  localparam int unsigned LevelWidth = 4;
  localparam int unsigned CountWidth = 8;

  // Encoding is fixed because the display decodes it directly.
  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StInit     = 3'd1,
    StPlay     = 3'd2,
    StSettle   = 3'd3,
    StCheck    = 3'd4,
    StWin      = 3'd5,
    StHit      = 3'd6,
    StGameOver = 3'd7
  } gameStateT;

  localparam logic [1:0] CodeWin  = 2'b11;
  localparam logic [1:0] CodeHit  = 2'b01;
  localparam logic [1:0] CodeNone = 2'b00;
  localparam logic [1:0] CodeErr  = 2'b10;

endpackage

// File: rtl/sc_hold_counter.sv
// Loadable down-counter with zero flag; decrements on tick, stops at zero.
module sc_hold_counter
  import sc_frog_game_controller_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [CountWidth-1:0] loadValue,
  input  logic                  tick,
  output logic                  zero
);

  logic [CountWidth-1:0] countQ;

  always_ff @(posedge clk) begin
    if (rst) begin
      countQ <= '0;
    end else if (load) begin
      countQ <= loadValue;
    end else if (tick && (countQ != '0)) begin
      countQ <= countQ - CountWidth'(1);
    end
  end

  assign zero = (countQ == '0);

endmodule

// File: rtl/sc_frog_game_controller.sv
// Frogger game sequencer: paces row shifts, samples the comparator, tracks lives and level.
module sc_frog_game_controller
  import sc_frog_game_controller_pkg::*;
#(
  parameter int unsigned LIVES_INIT    = 3,
  parameter int unsigned LEVEL_MAX     = 7,
  parameter int unsigned HOLD_TICKS    = 4,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic                  GAME_CTRL_CLOCK_50,
  input  logic                  GAME_CTRL_RESET_InHigh,
  input  logic                  GAME_CTRL_start_InLow,
  input  logic                  GAME_CTRL_tick_In,
  input  logic [1:0]            GAME_CTRL_win_InBUS,
  output logic                  GAME_CTRL_clear_Out,
  output logic                  GAME_CTRL_shift_Out,
  output logic                  GAME_CTRL_frogReset_Out,
  output logic [LivesWidth-1:0] GAME_CTRL_lives_OutBUS,
  output logic [LevelWidth-1:0] GAME_CTRL_level_OutBUS,
  output logic [2:0]            GAME_CTRL_state_OutBUS,
  output logic                  GAME_CTRL_gameOver_Out,
  output logic                  GAME_CTRL_codeErr_Out
);

  gameStateT             stateQ, stateD;
  logic [LivesWidth-1:0] livesQ, livesD;
  logic [LevelWidth-1:0] levelQ, levelD;
  logic                  codeErrQ, codeErrD;
  logic                  clearQ, clearD;
  logic                  shiftQ, shiftD;
  logic                  frogResetQ, frogResetD;
  logic                  startPrevQ;
  logic                  startFall;
  logic                  cntLoad, cntTick, cntZero;
  logic [CountWidth-1:0] cntLoadValue;

  assign startFall = startPrevQ && !GAME_CTRL_start_InLow;

  sc_hold_counter u_holdCounter (
    .clk       (GAME_CTRL_CLOCK_50),
    .rst       (GAME_CTRL_RESET_InHigh),
    .load      (cntLoad),
    .loadValue (cntLoadValue),
    .tick      (cntTick),
    .zero      (cntZero)
  );

  always_ff @(posedge GAME_CTRL_CLOCK_50) begin
    if (GAME_CTRL_RESET_InHigh) begin
      stateQ     <= StIdle;
      livesQ     <= '0;
      levelQ     <= '0;
      codeErrQ   <= 1'b0;
      clearQ     <= 1'b0;
      shiftQ     <= 1'b0;
      frogResetQ <= 1'b0;
      startPrevQ <= 1'b1;
    end else begin
      stateQ     <= stateD;
      livesQ     <= livesD;
      levelQ     <= levelD;
      codeErrQ   <= codeErrD;
      clearQ     <= clearD;
      shiftQ     <= shiftD;
      frogResetQ <= frogResetD;
      startPrevQ <= GAME_CTRL_start_InLow;
    end
  end

  always_comb begin
    stateD       = stateQ;
    livesD       = livesQ;
    levelD       = levelQ;
    codeErrD     = codeErrQ;
    clearD       = 1'b0;
    shiftD       = 1'b0;
    frogResetD   = 1'b0;
    cntLoad      = 1'b0;
    cntLoadValue = '0;
    cntTick      = 1'b0;
    unique case (stateQ)
      StIdle: if (startFall) stateD = StInit;
      StInit: begin
        clearD     = 1'b1;
        frogResetD = 1'b1;
        livesD     = LivesWidth'(LIVES_INIT);
        levelD     = LevelWidth'(1);
        stateD     = StPlay;
      end
      StPlay: if (GAME_CTRL_tick_In) begin
        shiftD       = 1'b1;
        stateD       = StSettle;
        cntLoad      = 1'b1;
        cntLoadValue = CountWidth'(SETTLE_CYCLES);
      end
      // Settle counts clock cycles, not frame ticks.
      StSettle: if (cntZero) stateD = StCheck; else cntTick = 1'b1;
      StCheck: begin
        unique case (GAME_CTRL_win_InBUS)
          CodeWin: begin
            stateD       = StWin;
            levelD       = (levelQ >= LevelWidth'(LEVEL_MAX)) ? LevelWidth'(LEVEL_MAX)
                                                              : levelQ + LevelWidth'(1);
            frogResetD   = 1'b1;
            cntLoad      = 1'b1;
            cntLoadValue = CountWidth'(HOLD_TICKS);
          end
          CodeHit: begin
            stateD       = StHit;
            livesD       = (livesQ != '0) ? livesQ - LivesWidth'(1) : '0;
            cntLoad      = 1'b1;
            cntLoadValue = CountWidth'(HOLD_TICKS);
          end
          CodeErr: begin
            codeErrD = 1'b1;
            stateD   = StPlay;
          end
          CodeNone: stateD = StPlay;
          default:  stateD = StPlay;
        endcase
      end
      StWin: if (cntZero) stateD = StPlay; else cntTick = GAME_CTRL_tick_In;
      StHit: begin
        if (cntZero) begin
          if (livesQ == '0) begin
            stateD = StGameOver;
          end else begin
            frogResetD = 1'b1;
            stateD     = StPlay;
          end
        end else begin
          cntTick = GAME_CTRL_tick_In;
        end
      end
      StGameOver: if (startFall) stateD = StInit;
      default: stateD = StIdle;
    endcase
  end

  assign GAME_CTRL_clear_Out     = clearQ;
  assign GAME_CTRL_shift_Out     = shiftQ;
  assign GAME_CTRL_frogReset_Out = frogResetQ;
  assign GAME_CTRL_lives_OutBUS  = livesQ;
  assign GAME_CTRL_level_OutBUS  = levelQ;
  assign GAME_CTRL_state_OutBUS  = stateQ;
  assign GAME_CTRL_gameOver_Out  = (stateQ == StGameOver);
  assign GAME_CTRL_codeErr_Out   = codeErrQ;

endmodule
